encode_reg_arith: RTL and testbench
===================================

// Module: encode_reg_arith
// PURPOSE
//   Inverse of the R-type arithmetic decoder. Takes a stream of (kind, rd, rs1, rs2) requests and
//   assembles 32-bit RV32I OP-class instruction words (opcode 7'b0110011).
//   Buffers them in a DEPTH-entry FIFO and emits each word with a sequential instruction-memory
//   address over a valid/ready stream. Used by the program loader and the self-test generator.
// PARAMETERS
//   DEPTH      4      FIFO entries; power of two, >= 2
//   ADDR_W     32     width of out_addr
//   BASE_ADDR  '0     address stamped on the first word after reset/flush
// PORTS
//   clk        in   1                   clock, rising edge
//   rst        in   1                   reset, asynchronous, active-low
//   flush      in   1                   sync clear of FIFO and address counter
//   in_valid   in   1                   request valid
//   in_ready   out  1                   request accepted when in_valid && in_ready
//   in_kind    in   reg_arith_kind_t    operation (instr_type package)
//   in_rd      in   5                   destination register
//   in_rs1     in   5                   source register 1
//   in_rs2     in   5                   source register 2
//   out_valid  out  1                   head word valid
//   out_ready  in   1                   consumer takes head when out_valid && out_ready
//   out_instr  out  32                  {funct7, rs2, rs1, funct3, rd, 7'b0110011}
//   out_addr   out  ADDR_W              address stamped on head word
//   illegal    out  1                   1-cycle pulse: accepted request had unencodable kind
//   count      out  $clog2(DEPTH+1)     current FIFO occupancy
// BEHAVIOUR
//   - Encoding (funct3/funct7): add 000/0000000, sub 000/0100000, sll 001/0, slt 010/0,
//     sltu 011/0, xor 100/0, srl 101/0, sra 101/0100000, or 110/0, and 111/0.
//   - Reset (rst=0, async): FIFO empty, count=0, out_valid=0, illegal=0, addr counter=BASE_ADDR.
//     in_ready=1 once rst=1. Reset mid-burst discards all buffered words.
//   - in_ready = (count < DEPTH) && !flush. Combinational from state and flush only; never
//     depends on out_ready.
//   - Accept of a legal kind at edge N: word and current addr counter are written to FIFO tail;
//     addr counter += 4, modulo 2^ADDR_W (wraps silently).
//     If the FIFO was empty, out_valid=1 after edge N (latency 1 cycle).
//   - Accept of any other kind value: nothing enqueued, addr counter unchanged, illegal=1 for
//     exactly the cycle after edge N.
//   - Output: out_instr/out_addr/out_valid hold stable while out_valid && !out_ready.
//     Pop on out_valid && out_ready. Strict FIFO order.
//     out_instr=0 and out_addr=0 whenever out_valid=0.
//   - Same-edge push and pop (count in 1..DEPTH-1): count unchanged, both take effect.
//     When full, in_ready=0, so no push occurs.
//   - flush=1 at an edge: highest priority over push and pop. FIFO empty, count=0,
//     addr counter=BASE_ADDR, no illegal pulse. out_valid=0 after the edge.
//   - count updates on the same edge as push/pop; it is a registered output.
// TESTING
//   1 DEPTH=4, BASE_ADDR=0, out_ready=1; push add x1,x2,x3 -> out_instr=0x003100B3,
//     out_addr=0, out_valid 1 cycle after accept.
//   2 Push sub x5,x6,x7; sra x10,x11,x12; and x31,x31,x31 -> 0x407302B3 @4,
//     0x40C5D533 @8, 0x01FFFFB3 @0xC. Then sweep all ten kinds and check every funct3/funct7.
//   3 out_ready=0, push 5 back-to-back -> in_ready=0 after 4th accept, count=4, head stable;
//     raise out_ready -> 4 words drain in order, count reaches 0.
//   4 Push invalid kind value between two adds -> illegal pulses once, count/addr unchanged,
//     adds get addrs 0 and 4.
//   5 3 words buffered, flush=1 with in_valid=1 -> count=0, out_valid=0, nothing pushed;
//     next push gets out_addr=BASE_ADDR.
//   6 ADDR_W=8, BASE_ADDR=8'hF8, three pushes -> F8, FC, 00. Drop rst mid-burst ->
//     immediately count=0, out_valid=0.

Source files
------------

// File: rtl/encode_reg_arith_if.sv
// -----------------------------------------------------------------------------
// instr_type / encode_reg_arith_if
//
// Purpose
//   instr_type holds the request kind enumeration shared by the R-type
//   arithmetic decoder and this encoder. encode_reg_arith_if bundles the
//   request stream, the output word stream and the status signals of
//   encode_reg_arith.
//
// Interface signals
//   flush      sync clear of FIFO and address counter (producer -> encoder)
//   in_valid   request valid                          (producer -> encoder)
//   in_ready   request accepted when in_valid&&in_ready (encoder -> producer)
//   in_kind    operation kind                         (producer -> encoder)
//   in_rd      destination register                   (producer -> encoder)
//   in_rs1     source register 1                      (producer -> encoder)
//   in_rs2     source register 2                      (producer -> encoder)
//   out_valid  head word valid                        (encoder -> consumer)
//   out_ready  consumer takes head word               (consumer -> encoder)
//   out_instr  assembled instruction word             (encoder -> consumer)
//   out_addr   address stamped on the head word       (encoder -> consumer)
//   illegal    1-cycle pulse on unencodable request   (encoder -> producer)
//   count      current FIFO occupancy                 (encoder -> producer)
//
// Modports
//   master  the producer/consumer side driving requests and out_ready
//   slave   the encoder side
// -----------------------------------------------------------------------------

package instr_type;

    // Values 10..15 have no R-type arithmetic encoding.
    typedef enum logic [3:0] {
        RA_ADD  = 4'd0,
        RA_SUB  = 4'd1,
        RA_SLL  = 4'd2,
        RA_SLT  = 4'd3,
        RA_SLTU = 4'd4,
        RA_XOR  = 4'd5,
        RA_SRL  = 4'd6,
        RA_SRA  = 4'd7,
        RA_OR   = 4'd8,
        RA_AND  = 4'd9
    } reg_arith_kind_t;

endpackage

interface encode_reg_arith_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    instr_type::reg_arith_kind_t in_kind;
    logic [4:0]                  in_rd;
    logic [4:0]                  in_rs1;
    logic [4:0]                  in_rs2;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_instr;
    logic [ADDR_W-1:0]           out_addr;
    logic                        illegal;
    logic [CNT_W-1:0]            count;

    modport master (
        output flush,
        output in_valid,
        output in_kind,
        output in_rd,
        output in_rs1,
        output in_rs2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_addr,
        input  illegal,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_kind,
        input  in_rd,
        input  in_rs1,
        input  in_rs2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_addr,
        output illegal,
        output count
    );

endinterface

// File: rtl/encode_reg_arith.sv
// -----------------------------------------------------------------------------
// encode_reg_arith
//
// Purpose
//   Assembles RV32I OP-class (opcode 7'b0110011) instruction words from a
//   stream of (kind, rd, rs1, rs2) requests, buffers them in a DEPTH-entry
//   FIFO together with a sequential instruction-memory address, and presents
//   them on a valid/ready output stream.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   ADDR_W     width of out_addr
//   BASE_ADDR  address of the first word after reset or flush
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   bus        encode_reg_arith_if.slave (request stream, word stream,
//              flush, illegal pulse, occupancy count)
// -----------------------------------------------------------------------------

module encode_reg_arith #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    encode_reg_arith_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    // Kind codes; these mirror instr_type::reg_arith_kind_t.
    localparam logic [3:0] KIND_ADD  = 4'd0;
    localparam logic [3:0] KIND_SUB  = 4'd1;
    localparam logic [3:0] KIND_SLL  = 4'd2;
    localparam logic [3:0] KIND_SLT  = 4'd3;
    localparam logic [3:0] KIND_SLTU = 4'd4;
    localparam logic [3:0] KIND_XOR  = 4'd5;
    localparam logic [3:0] KIND_SRL  = 4'd6;
    localparam logic [3:0] KIND_SRA  = 4'd7;
    localparam logic [3:0] KIND_OR   = 4'd8;
    localparam logic [3:0] KIND_AND  = 4'd9;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True for the ten kinds that have an encoding.
    function automatic logic kind_legal(input logic [3:0] kind);
        logic ok;
        case (kind)
            KIND_ADD, KIND_SUB, KIND_SLL, KIND_SLT, KIND_SLTU,
            KIND_XOR, KIND_SRL, KIND_SRA, KIND_OR,  KIND_AND: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {funct7, funct3}; unencodable kinds yield zero and are never enqueued.
    function automatic logic [9:0] kind_funct(input logic [3:0] kind);
        logic [9:0] f;
        case (kind)
            KIND_ADD:  f = {F7_BASE, 3'b000};
            KIND_SUB:  f = {F7_ALT,  3'b000};
            KIND_SLL:  f = {F7_BASE, 3'b001};
            KIND_SLT:  f = {F7_BASE, 3'b010};
            KIND_SLTU: f = {F7_BASE, 3'b011};
            KIND_XOR:  f = {F7_BASE, 3'b100};
            KIND_SRL:  f = {F7_BASE, 3'b101};
            KIND_SRA:  f = {F7_ALT,  3'b101};
            KIND_OR:   f = {F7_BASE, 3'b110};
            KIND_AND:  f = {F7_BASE, 3'b111};
            default:   f = 10'd0;
        endcase
        return f;
    endfunction

    // FIFO payload storage
    logic [31:0]       mem_instr_r [DEPTH];
    logic [ADDR_W-1:0] mem_addr_r  [DEPTH];

    // Control state
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              out_valid_r;
    logic              illegal_r;
    logic [ADDR_W-1:0] addr_cnt_r;

    // Combinational control
    logic [3:0]        kind_s;
    logic [9:0]        funct_s;
    logic [31:0]       word_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              legal_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [31:0]       out_instr_s;
    logic [ADDR_W-1:0] out_addr_s;

    // Request qualification, word assembly and next occupancy.
    always_comb begin
        kind_s      = bus.in_kind;
        funct_s     = kind_funct(kind_s);
        word_s      = {funct_s[9:3], bus.in_rs2, bus.in_rs1, funct_s[2:0], bus.in_rd, OPCODE_OP};
        // in_ready looks only at occupancy and flush, never at out_ready, so a
        // full FIFO refuses a request even if the head is leaving this cycle.
        in_ready_s  = (count_r < CNT_W'(DEPTH)) && !bus.flush;
        accept_s    = bus.in_valid && in_ready_s;
        legal_s     = kind_legal(kind_s);
        push_s      = accept_s && legal_s;
        pop_s       = out_valid_r && bus.out_ready && !bus.flush;
        count_nxt_s = count_r;
        if (bus.flush) begin
            count_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy, address counter and status flags; flush outranks push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            addr_cnt_r  <= BASE_ADDR;
        end else if (bus.flush) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            addr_cnt_r  <= BASE_ADDR;
        end else begin
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1'b1);
                // Wraps silently modulo 2^ADDR_W.
                addr_cnt_r <= addr_cnt_r + ADDR_W'(3'd4);
            end else begin
                wr_ptr_r   <= wr_ptr_r;
                addr_cnt_r <= addr_cnt_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            illegal_r   <= accept_s && !legal_s;
        end
    end

    // Payload write at the tail; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_instr_r[wr_ptr_r] <= word_s;
            mem_addr_r[wr_ptr_r]  <= addr_cnt_r;
        end
    end

    // Head presentation, forced to zero while no word is valid.
    always_comb begin
        out_instr_s = 32'd0;
        out_addr_s  = '0;
        if (out_valid_r) begin
            out_instr_s = mem_instr_r[rd_ptr_r];
            out_addr_s  = mem_addr_r[rd_ptr_r];
        end else begin
            out_instr_s = 32'd0;
            out_addr_s  = '0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_s;
    assign bus.out_addr  = out_addr_s;
    assign bus.illegal   = illegal_r;
    assign bus.count     = count_r;

endmodule

// File: tb/tb_encode_reg_arith.sv
module tb_encode_reg_arith;
    import instr_type::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_b;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0;

    encode_reg_arith_if #(.DEPTH(4), .ADDR_W(32)) bus ();
    encode_reg_arith_if #(.DEPTH(4), .ADDR_W(8))  bus_b ();

    encode_reg_arith #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    encode_reg_arith #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'hF8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    // Reference encoding straight from the funct3/funct7 table.
    function automatic logic [31:0] exp_word(input logic [3:0] k, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
        logic [2:0] f3;
        logic [6:0] f7;
        f7 = 7'b0000000;
        case (k)
            4'd0: f3 = 3'b000;
            4'd1: begin f3 = 3'b000; f7 = 7'b0100000; end
            4'd2: f3 = 3'b001;
            4'd3: f3 = 3'b010;
            4'd4: f3 = 3'b011;
            4'd5: f3 = 3'b100;
            4'd6: f3 = 3'b101;
            4'd7: begin f3 = 3'b101; f7 = 7'b0100000; end
            4'd8: f3 = 3'b110;
            4'd9: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // One clock: at the falling edge note acceptance and score any departing word.
    task automatic tick(output logic acc);
        logic [63:0] e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got addr=%h instr=%h, required no word",
                         bus.out_addr, bus.out_instr);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_addr, bus.out_instr} !== e) begin
                    bad++;
                    $display("FAIL scoreboard_word: got addr=%h instr=%h, required addr=%h instr=%h",
                             bus.out_addr, bus.out_instr, e[63:32], e[31:0]);
                end
            end
        end else if (rst && !bus.out_valid) begin
            total++;
            if ({bus.out_addr, bus.out_instr} !== 64'h0) begin
                bad++;
                $display("FAIL idle_zero: got addr=%h instr=%h, required 0 0",
                         bus.out_addr, bus.out_instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic legal, input logic [31:0] want);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_kind  = reg_arith_kind_t'(k);
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL push_timeout: got no accept in %0d cycles, required accept", n);
        end else if (legal) begin
            exp_q.push_back({exp_addr, want});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic drain(input int cycles);
        logic acc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) tick(acc);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_empty: got %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_flush();
        logic acc;
        bus.flush = 1'b1;
        tick(acc);
        bus.flush = 1'b0;
        exp_q.delete();
        exp_addr = 32'h0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        rst_b = 1'b0;
        #12;
        total++;
        if ({bus.count, bus.out_valid, bus.illegal} !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: got count=%0d valid=%b illegal=%b, required 0 0 0",
                     bus.count, bus.out_valid, bus.illegal);
        end
        #8;
        rst   = 1'b1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_instr !== 32'h0 || bus.count !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b instr=%h count=%0d, required 1 0 0",
                     bus.in_ready, bus.out_instr, bus.count);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pre_valid: got %b, required 0", bus.out_valid);
        end
        push(4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h003100B3);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h003100B3 || bus.out_addr !== 32'h0) begin
            bad++;
            $display("FAIL basic_latency: got valid=%b instr=%h addr=%h, required 1 003100b3 0",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        drain(3);
    endtask

    task automatic test_encodings();
        logic [4:0] rd, rs1, rs2;
        bus.out_ready = 1'b1;
        push(4'd1, 5'd5,  5'd6,  5'd7,  1'b1, 32'h407302B3);
        push(4'd7, 5'd10, 5'd11, 5'd12, 1'b1, 32'h40C5D533);
        push(4'd9, 5'd31, 5'd31, 5'd31, 1'b1, 32'h01FFFFB3);
        for (int k = 0; k < 10; k++) begin
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            push(4'(k), rd, rs1, rs2, 1'b1, exp_word(4'(k), rd, rs1, rs2));
        end
        drain(4);
    endtask

    task automatic test_back_to_back();
        logic        acc;
        logic [63:0] head;
        int          n;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(4'd5, 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1,
                 exp_word(4'd5, 5'(i + 1), 5'(i + 2), 5'(i + 3)));
        total++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_state: got count=%0d in_ready=%b, required 4 0",
                     bus.count, bus.in_ready);
        end
        head = {bus.out_addr, bus.out_instr};
        bus.in_valid = 1'b1;
        bus.in_kind  = RA_OR;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            total++;
            if (acc !== 1'b0 || {bus.out_addr, bus.out_instr} !== head || bus.count !== 3'd4) begin
                bad++;
                $display("FAIL full_hold: got acc=%b head=%h count=%0d, required 0 %h 4",
                         acc, {bus.out_addr, bus.out_instr}, bus.count, head);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.count != 3'd0 && n < 10) begin
            tick(acc);
            n++;
        end
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_drain: got count=%0d valid=%b pending=%0d, required 0 0 0",
                     bus.count, bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_illegal();
        logic acc;
        do_flush();
        bus.out_ready = 1'b0;
        push(4'd0, 5'd1, 5'd1, 5'd1, 1'b1, exp_word(4'd0, 5'd1, 5'd1, 5'd1));
        push(4'd12, 5'd3, 5'd3, 5'd3, 1'b0, 32'h0);
        total++;
        if (bus.illegal !== 1'b1 || bus.count !== 3'd1) begin
            bad++;
            $display("FAIL illegal_pulse: got illegal=%b count=%0d, required 1 1",
                     bus.illegal, bus.count);
        end
        tick(acc);
        total++;
        if (bus.illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_width: got %b, required 0", bus.illegal);
        end
        push(4'd0, 5'd2, 5'd2, 5'd2, 1'b1, exp_word(4'd0, 5'd2, 5'd2, 5'd2));
        total++;
        if (bus.count !== 3'd2 || bus.illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_count: got count=%0d illegal=%b, required 2 0",
                     bus.count, bus.illegal);
        end
        drain(4);
    endtask

    task automatic test_flush();
        logic acc;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(4'd8, 5'(i), 5'(i), 5'(i), 1'b1, exp_word(4'd8, 5'(i), 5'(i), 5'(i)));
        total++;
        if (bus.count !== 3'd3) begin
            bad++;
            $display("FAIL flush_pre_count: got %0d, required 3", bus.count);
        end
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_kind  = RA_ADD;
        tick(acc);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_addr = 32'h0;
        total++;
        if (acc !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0 ||
            bus.illegal !== 1'b0 || bus.out_instr !== 32'h0) begin
            bad++;
            $display("FAIL flush_state: got acc=%b count=%0d valid=%b illegal=%b instr=%h, required 0 0 0 0 0",
                     acc, bus.count, bus.out_valid, bus.illegal, bus.out_instr);
        end
        bus.out_ready = 1'b1;
        push(4'd0, 5'd4, 5'd4, 5'd4, 1'b1, exp_word(4'd0, 5'd4, 5'd4, 5'd4));
        total++;
        if (bus.out_addr !== 32'h0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_base: got addr=%h valid=%b, required 0 1", bus.out_addr, bus.out_valid);
        end
        drain(3);
    endtask

    task automatic push_b(input logic [4:0] r);
        logic acc;
        int   n;
        bus_b.in_valid = 1'b1;
        bus_b.in_kind  = RA_ADD;
        bus_b.in_rd    = r;
        bus_b.in_rs1   = r;
        bus_b.in_rs2   = r;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus_b.in_valid && bus_b.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus_b.in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL push_b_timeout: got no accept in %0d cycles, required accept", n);
        end
    endtask

    task automatic test_wrap_reset();
        logic [7:0] wa [3];
        wa[0] = 8'hF8;
        wa[1] = 8'hFC;
        wa[2] = 8'h00;
        bus_b.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_b(5'(i + 1));
        total++;
        if (bus_b.count !== 3'd3) begin
            bad++;
            $display("FAIL wrap_count: got %0d, required 3", bus_b.count);
        end
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus_b.out_valid !== 1'b1 || bus_b.out_addr !== wa[i] ||
                bus_b.out_instr !== exp_word(4'd0, 5'(i + 1), 5'(i + 1), 5'(i + 1))) begin
                bad++;
                $display("FAIL wrap_addr%0d: got valid=%b addr=%h instr=%h, required 1 %h %h",
                         i, bus_b.out_valid, bus_b.out_addr, bus_b.out_instr, wa[i],
                         exp_word(4'd0, 5'(i + 1), 5'(i + 1), 5'(i + 1)));
            end
            @(posedge clk);
            #1;
        end
        bus_b.out_ready = 1'b0;
        push_b(5'd4);
        push_b(5'd5);
        total++;
        if (bus_b.count !== 3'd2 || bus_b.out_addr !== 8'h04) begin
            bad++;
            $display("FAIL wrap_continue: got count=%0d addr=%h, required 2 04",
                     bus_b.count, bus_b.out_addr);
        end
        #2;
        rst_b = 1'b0;
        #1;
        total++;
        if (bus_b.count !== 3'd0 || bus_b.out_valid !== 1'b0 || bus_b.out_instr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got count=%0d valid=%b instr=%h, required 0 0 0",
                     bus_b.count, bus_b.out_valid, bus_b.out_instr);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        push_b(5'd6);
        total++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_addr !== 8'hF8) begin
            bad++;
            $display("FAIL reset_base: got valid=%b addr=%h, required 1 f8",
                     bus_b.out_valid, bus_b.out_addr);
        end
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_kind     = RA_ADD;
        bus.in_rd       = 5'd0;
        bus.in_rs1      = 5'd0;
        bus.in_rs2      = 5'd0;
        bus.out_ready   = 1'b0;
        bus_b.flush     = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_kind   = RA_ADD;
        bus_b.in_rd     = 5'd0;
        bus_b.in_rs1    = 5'd0;
        bus_b.in_rs2    = 5'd0;
        bus_b.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_encodings();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_wrap_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
